sysid_checker_master: RTL and testbench

- Avalon-MM read master that sits opposite the system-ID control slave (1-bit address, 32-bit readdata).
- On a start pulse it reads word 0 (system ID) and then word 1 (build timestamp), and compares both against parameterised expected values.
- Reports pass/fail and timeout, and holds the captured words.
- Used by boot/self-test logic to confirm the loaded FPGA image matches the software build before releasing the CPU subsystem.

---
 rtl/sysid_checker_master.sv | 213 +++++++++++++++++++++
 tb/tb_sysid_checker_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker_master.sv
// Avalon-MM read master that fetches the system-ID and build-timestamp words
// and compares them against the values this image was built with.
module sysid_checker_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1516721602,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int                 STALL_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]         LAT_LAST   = 2'(READ_LATENCY - 1);
  localparam bit                 NO_LATENCY = (READ_LATENCY == 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_ID = 3'd1,
    LAT_ID = 3'd2,
    REQ_TS = 3'd3,
    LAT_TS = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_next;
  logic [1:0]         lat_cnt;
  logic [1:0]         lat_next;
  logic [31:0]        id_next;
  logic [31:0]        ts_next;
  logic               id_ok_next;
  logic               ts_ok_next;
  logic               pass_next;
  logic               timeout_next;
  logic               busy_next;
  logic               done_next;
  logic               read_next;
  logic               address_next;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_next   = state;
    stall_next   = stall_cnt;
    lat_next     = lat_cnt;
    id_next      = id_value;
    ts_next      = ts_value;
    id_ok_next   = id_ok;
    ts_ok_next   = ts_ok;
    pass_next    = pass;
    timeout_next = timeout;
    busy_next    = busy;
    done_next    = done;
    read_next    = avm_read;
    address_next = avm_address;

    case (state)
      IDLE: begin
        if (start) begin
          state_next   = REQ_ID;
          busy_next    = 1'b1;
          done_next    = 1'b0;
          pass_next    = 1'b0;
          id_ok_next   = 1'b0;
          ts_ok_next   = 1'b0;
          timeout_next = 1'b0;
          stall_next   = '0;
          lat_next     = 2'd0;
          id_next      = 32'd0;
          ts_next      = 32'd0;
          read_next    = 1'b1;
          address_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end

      REQ_ID: begin
        if (!avm_waitrequest) begin
          if (NO_LATENCY) begin
            // Zero-latency slave: data is on the bus in the accepting cycle.
            id_next      = avm_readdata;
            state_next   = REQ_TS;
            address_next = 1'b1;
            stall_next   = '0;
          end else begin
            state_next = LAT_ID;
            read_next  = 1'b0;
            lat_next   = 2'd0;
          end
        end else if (stall_cnt == STALL_LAST) begin
          state_next   = FIN;
          read_next    = 1'b0;
          timeout_next = 1'b1;
        end else begin
          stall_next = stall_cnt + 1'b1;
        end
      end

      LAT_ID: begin
        if (lat_cnt == LAT_LAST) begin
          id_next      = avm_readdata;
          state_next   = REQ_TS;
          read_next    = 1'b1;
          address_next = 1'b1;
          stall_next   = '0;
        end else begin
          lat_next = lat_cnt + 2'd1;
        end
      end

      REQ_TS: begin
        if (!avm_waitrequest) begin
          read_next = 1'b0;
          if (NO_LATENCY) begin
            ts_next      = avm_readdata;
            state_next   = FIN;
            address_next = 1'b0;
          end else begin
            state_next = LAT_TS;
            lat_next   = 2'd0;
          end
        end else if (stall_cnt == STALL_LAST) begin
          state_next   = FIN;
          read_next    = 1'b0;
          address_next = 1'b0;
          timeout_next = 1'b1;
        end else begin
          stall_next = stall_cnt + 1'b1;
        end
      end

      LAT_TS: begin
        if (lat_cnt == LAT_LAST) begin
          ts_next      = avm_readdata;
          state_next   = FIN;
          address_next = 1'b0;
        end else begin
          lat_next = lat_cnt + 2'd1;
        end
      end

      FIN: begin
        // An uncaptured word is still 0 here, so the verdict needs ~timeout too.
        id_ok_next   = (id_value == EXPECTED_ID);
        ts_ok_next   = (ts_value == EXPECTED_TIMESTAMP);
        pass_next    = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP) && !timeout;
        done_next    = 1'b1;
        busy_next    = 1'b0;
        read_next    = 1'b0;
        address_next = 1'b0;
        state_next   = IDLE;
      end

      default: begin
        state_next   = IDLE;
        busy_next    = 1'b0;
        read_next    = 1'b0;
        address_next = 1'b0;
      end
    endcase
  end

  // State, counters, captured words and all outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      stall_cnt   <= '0;
      lat_cnt     <= 2'd0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
    end else begin
      state       <= state_next;
      stall_cnt   <= stall_next;
      lat_cnt     <= lat_next;
      id_value    <= id_next;
      ts_value    <= ts_next;
      id_ok       <= id_ok_next;
      ts_ok       <= ts_ok_next;
      pass        <= pass_next;
      timeout     <= timeout_next;
      busy        <= busy_next;
      done        <= done_next;
      avm_read    <= read_next;
      avm_address <= address_next;
    end
  end

endmodule

// File: tb/tb_sysid_checker_master.sv
// Directed bench: three checker instances (default, short timeout, latency 2)
// each facing a small sysid slave model.
module tb_sysid_checker_master;

  localparam logic [31:0] TS  = 32'd1516721602;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [31:0] id_model = 32'd0;
  logic [31:0] ts_model = TS;

  logic        start0 = 1'b0, wait0 = 1'b0;
  logic        start1 = 1'b0, wait1 = 1'b1;
  logic        start2 = 1'b0, wait2 = 1'b0;
  logic        addr0, read0, busy0, done0, pass0, idok0, tsok0, to0;
  logic        addr1, read1, busy1, done1, pass1, idok1, tsok1, to1;
  logic        addr2, read2, busy2, done2, pass2, idok2, tsok2, to2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic [31:0] idv0, tsv0, idv1, tsv1, idv2, tsv2;

  assign rdata0 = addr0 ? ts_model : id_model;
  assign rdata1 = addr1 ? ts_model : id_model;

  // Latency-2 slave: data is valid only in the second cycle after acceptance.
  logic [1:0] pend;
  logic       paddr;
  always @(posedge clock) begin
    if (reset) begin
      pend  <= 2'd0;
      paddr <= 1'b0;
    end else if (read2 && !wait2) begin
      pend  <= 2'd2;
      paddr <= addr2;
    end else if (pend != 2'd0) begin
      pend <= pend - 2'd1;
    end
  end
  assign rdata2 = (pend == 2'd1) ? (paddr ? TS : 32'd0) : BAD;

  sysid_checker_master dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wait0), .avm_readdata(rdata0),
    .busy(busy0), .done(done0), .pass(pass0), .id_ok(idok0), .ts_ok(tsok0),
    .timeout(to0), .id_value(idv0), .ts_value(tsv0)
  );

  sysid_checker_master #(.TIMEOUT_CYCLES(4)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .avm_address(addr1), .avm_read(read1), .avm_waitrequest(wait1), .avm_readdata(rdata1),
    .busy(busy1), .done(done1), .pass(pass1), .id_ok(idok1), .ts_ok(tsok1),
    .timeout(to1), .id_value(idv1), .ts_value(tsv1)
  );

  sysid_checker_master #(.READ_LATENCY(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2),
    .avm_address(addr2), .avm_read(read2), .avm_waitrequest(wait2), .avm_readdata(rdata2),
    .busy(busy2), .done(done2), .pass(pass2), .id_ok(idok2), .ts_ok(tsok2),
    .timeout(to2), .id_value(idv2), .ts_value(tsv2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tick();
    tick();
    check_eq("rst_outs0", {30'd0, read0, addr0, busy0, done0, pass0, idok0, tsok0, to0}, 32'd0);
    check_eq("rst_outs1", {30'd0, read1, addr1, busy1, done1, pass1, idok1, tsok1, to1}, 32'd0);
    check_eq("rst_ts0", tsv0, 32'd0);
    reset = 1'b0;
    tick();

    // Basic check against a zero-wait, zero-latency sysid slave.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_eq("t1_req_id", {28'd0, read0, addr0, busy0, done0}, 32'b1010);
    tick();
    check_eq("t1_req_ts", {30'd0, read0, addr0}, 32'b11);
    tick();
    check_eq("t1_fin", {29'd0, read0, busy0, done0}, 32'b010);
    tick();
    check_eq("t1_flags", {26'd0, done0, busy0, pass0, idok0, tsok0, to0}, 32'b101110);
    check_eq("t1_id", idv0, 32'd0);
    check_eq("t1_ts", tsv0, TS);

    // Wrong timestamp from the slave.
    ts_model = TS + 32'd1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_eq("t2_done_clr", {31'd0, done0}, 32'd0);
    tick();
    tick();
    tick();
    check_eq("t2_flags", {27'd0, done0, pass0, idok0, tsok0, to0}, 32'b10100);
    check_eq("t2_ts", tsv0, TS + 32'd1);
    ts_model = TS;

    // Ten stall cycles on each read.
    wait0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("t3_stall_id", {30'd0, read0, addr0}, 32'b10);
      tick();
    end
    wait0 = 1'b0;
    tick();
    wait0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("t3_stall_ts", {30'd0, read0, addr0}, 32'b11);
      tick();
    end
    wait0 = 1'b0;
    tick();
    check_eq("t3_n22", {30'd0, read0, done0}, 32'b00);
    tick();
    check_eq("t3_n23", {29'd0, done0, pass0, to0}, 32'b110);
    check_eq("t3_ts", tsv0, TS);

    // Stuck waitrequest with TIMEOUT_CYCLES=4.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq("t4_req", {30'd0, read1, addr1}, 32'b10);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t4_stall", {30'd0, read1, addr1}, 32'b10);
    end
    tick();
    check_eq("t4_drop", {29'd0, read1, busy1, done1}, 32'b010);
    tick();
    check_eq("t4_flags", {26'd0, done1, busy1, pass1, to1, idok1, tsok1}, 32'b100110);
    check_eq("t4_words", {idv1 | tsv1}, 32'd0);

    // READ_LATENCY=2, with start pulses while busy and in FIN.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    check_eq("t5_read_drop", {31'd0, read2}, 32'd0);
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check_eq("t5_req_ts", {30'd0, read2, addr2}, 32'b11);
    tick();
    tick();
    tick();
    check_eq("t5_n6", {30'd0, busy2, done2}, 32'b10);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check_eq("t5_n7", {29'd0, done2, busy2, pass2}, 32'b101);
    check_eq("t5_id", idv2, 32'd0);
    check_eq("t5_ts", tsv2, TS);
    tick();
    check_eq("t5_no_restart", {29'd0, done2, busy2, read2}, 32'b100);

    // Reset while the timestamp read is outstanding.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    check_eq("t6_in_ts", {30'd0, read0, addr0}, 32'b11);
    reset = 1'b1;
    tick();
    check_eq("t6_rst_outs", {30'd0, read0, addr0, busy0, done0, pass0, idok0, tsok0, to0}, 32'd0);
    check_eq("t6_rst_words", {idv0 | tsv0}, 32'd0);
    reset = 1'b0;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    tick();
    check_eq("t6_rerun", {29'd0, done0, pass0, busy0}, 32'b110);
    check_eq("t6_rerun_ts", tsv0, TS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
